// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder stage, the sum accumulator and its result consumer.
// The master modport is the side that drives words and accepts results; the slave modport is the accumulator.
interface sum_accumulator_if #(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned ACC_W = 7
) ();
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates blocks of COUNT adder sum words into an ACC_W-bit total with a sticky carry-out flag,
// holding each result until the downstream handshake.
module sum_accumulator #(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned ACC_W = 7,
    parameter int unsigned COUNT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sum_accumulator_if.slave  bus
);
    localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;

    logic [IN_W-1:0]  data_c;
    logic [ACC_W:0]   sum_c;

    // Widened add so the carry out of the accumulator is visible in the top bit.
    assign data_c = bus.in_data;
    assign sum_c  = {1'b0, acc_q} + (ACC_W + 1)'(data_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = sum_c[ACC_W-1:0];
                    ovf_d = ovf_q | sum_c[ACC_W];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d     = HOLD;
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        out_sum_d   = sum_c[ACC_W-1:0];
                        out_ovf_d   = ovf_q | sum_c[ACC_W];
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    // A start in the handshake cycle chains straight into the next block.
                    if (bus.start) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered copies of state decodes keep these outputs free of input paths.
        in_ready_d = (state_d == ACCUM);
        busy_d     = (state_d != IDLE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a block-level model checked every cycle plus literal result checks.
module tb_sum_accumulator;
    localparam int unsigned IN_W  = 5;
    localparam int unsigned ACC_W = 7;
    localparam int unsigned COUNT = 8;
    localparam int MOD = 1 << ACC_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sum_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

    sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit done  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Block model: phase 0 idle, 1 collecting words, 2 result waiting for the consumer.
    int m_phase, m_n, m_total;
    int exp_valid, exp_sum, exp_ovf;

    always @(posedge clk or negedge rst_n) begin : model
        int t;
        if (!rst_n) begin
            m_phase   <= 0;
            m_n       <= 0;
            m_total   <= 0;
            exp_valid <= 0;
            exp_sum   <= 0;
            exp_ovf   <= 0;
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    m_phase <= 1;
                    m_n     <= 0;
                    m_total <= 0;
                end
                1: if (bus.in_valid) begin
                    t = m_total + int'(bus.in_data);
                    m_total <= t;
                    m_n     <= m_n + 1;
                    if (m_n + 1 == int'(COUNT)) begin
                        m_phase   <= 2;
                        exp_valid <= 1;
                        exp_sum   <= t % MOD;
                        exp_ovf   <= (t >= MOD) ? 1 : 0;
                    end
                end
                default: if (bus.out_ready) begin
                    exp_valid <= 0;
                    if (bus.start) begin
                        m_phase <= 1;
                        m_n     <= 0;
                        m_total <= 0;
                    end else begin
                        m_phase <= 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            check("cyc_out_valid", int'(bus.out_valid), exp_valid);
            check("cyc_busy", int'(bus.busy), (m_phase != 0) ? 1 : 0);
            check("cyc_in_ready", int'(bus.in_ready), (m_phase == 1) ? 1 : 0);
            check("cyc_out_sum", int'(bus.out_sum), exp_sum);
            check("cyc_out_ovf", int'(bus.out_ovf), exp_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input int w);
        bus.in_valid = 1'b1;
        bus.in_data  = IN_W'(w);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_n(input int w, input int n);
        for (int i = 0; i < n; i++) send(w);
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic expect_result(input string name, input int sum, input int ovf);
        check({name, "_valid"}, int'(bus.out_valid), 1);
        check({name, "_sum"}, int'(bus.out_sum), sum);
        check({name, "_ovf"}, int'(bus.out_ovf), ovf);
        check({name, "_in_ready"}, int'(bus.in_ready), 0);
    endtask

    task automatic expect_cleared(input string name);
        check({name, "_valid"}, int'(bus.out_valid), 0);
        check({name, "_sum"}, int'(bus.out_sum), 0);
        check({name, "_ovf"}, int'(bus.out_ovf), 0);
        check({name, "_busy"}, int'(bus.busy), 0);
        check({name, "_in_ready"}, int'(bus.in_ready), 0);
    endtask

    initial begin
        int bw[6] = '{5, 5, 5, 5, 5, 6};
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        expect_cleared("rst_hold");
        rst_n = 1'b1;
        tick();
        expect_cleared("rst_release");

        // Basic sum 1..8
        do_start();
        check("basic_busy", int'(bus.busy), 1);
        check("basic_in_ready", int'(bus.in_ready), 1);
        for (int i = 1; i <= 8; i++) send(i);
        expect_result("basic", 36, 0);
        accept();
        check("basic_idle_busy", int'(bus.busy), 0);
        check("basic_kept_sum", int'(bus.out_sum), 36);

        // Overflow, then a clean block clears the flag
        do_start();
        send_n(31, 8);
        expect_result("ovf", 120, 1);
        accept();
        do_start();
        send_n(1, 8);
        expect_result("ovf_clear", 8, 0);
        accept();

        // Bubbles between words
        do_start();
        send(5);
        repeat (3) tick();
        send(10);
        foreach (bw[i]) send(bw[i]);
        expect_result("bubble", 46, 0);

        // Backpressure: result held, input and start ignored
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = IN_W'(31);
            bus.start    = (i == 2);
            tick();
            check("bp_valid", int'(bus.out_valid), 1);
            check("bp_sum", int'(bus.out_sum), 46);
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        accept();
        check("bp_idle_busy", int'(bus.busy), 0);

        // Asynchronous reset mid-block discards partial words
        do_start();
        send_n(7, 3);
        #2 rst_n = 1'b0;
        #1 expect_cleared("rst_mid_block");
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_start();
        send_n(2, 8);
        expect_result("after_rst", 16, 0);
        accept();

        // Asynchronous reset while a result is held
        do_start();
        send_n(31, 8);
        expect_result("pre_rst_hold", 120, 1);
        #2 rst_n = 1'b0;
        #1 expect_cleared("rst_in_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back blocks: start together with the result handshake
        do_start();
        send_n(3, 8);
        expect_result("b2b_first", 24, 0);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("b2b_busy", int'(bus.busy), 1);
        check("b2b_in_ready", int'(bus.in_ready), 1);
        check("b2b_valid_low", int'(bus.out_valid), 0);
        check("b2b_kept_sum", int'(bus.out_sum), 24);
        send_n(10, 8);
        expect_result("b2b_second", 80, 0);
        accept();
        tick();
        check("end_busy", int'(bus.busy), 0);

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
